// File: rtl/note_scheduler.sv
// note_scheduler: steps through a song ROM, playing each note for
// dur*UNIT_TICKS tick strobes by programming a tone divider.
// Optional build macro NOTE_GAP_EN inserts GAP_TICKS silent ticks between notes;
// without it GAP logic is absent and GAP_TICKS is ignored.
module note_scheduler #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned UNIT_TICKS = 16,
  parameter int unsigned GAP_TICKS  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [11:0]       div_limit,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
`ifdef NOTE_GAP_EN
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
`ifdef NOTE_GAP_EN
    S_GAP   = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [11:0]         r_div_limit;
  logic                r_tone_en;
  logic                r_busy;
  logic                r_done;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [3:0]          r_unit_cnt;
`ifdef NOTE_GAP_EN
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [GAP_W-1:0]    w_gap_cnt_nxt;
`endif

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_rom_addr_nxt;
  logic [11:0]         w_div_limit_nxt;
  logic                w_tone_en_nxt;
  logic [TICK_W-1:0]   w_tick_cnt_nxt;
  logic [3:0]          w_unit_cnt_nxt;
  logic [3:0]          w_dur;
  logic [11:0]         w_half;

  assign w_dur  = rom_data[15:12];
  assign w_half = rom_data[11:0];

  // Next-state and next-output logic; stop overrides everything outside IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_div_limit_nxt = r_div_limit;
    w_tone_en_nxt   = r_tone_en;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_unit_cnt_nxt  = r_unit_cnt;
`ifdef NOTE_GAP_EN
    w_gap_cnt_nxt   = r_gap_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_rom_addr_nxt = '0;
        w_tone_en_nxt  = 1'b0;
        if (start && !stop) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_dur == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_div_limit_nxt = w_half;
          w_tone_en_nxt   = (w_half != 12'd0);
          w_tick_cnt_nxt  = '0;
          w_unit_cnt_nxt  = w_dur;
          w_state_nxt     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_cnt_nxt = '0;
            w_unit_cnt_nxt = r_unit_cnt - 4'd1;
            if (r_unit_cnt == 4'd1) begin
              w_tone_en_nxt = 1'b0;
              if (r_rom_addr == ADDR_LAST) begin
                w_state_nxt = S_DONE;
              end else begin
                w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
`ifdef NOTE_GAP_EN
                w_gap_cnt_nxt  = '0;
                w_state_nxt    = (GAP_TICKS == 0) ? S_FETCH : S_GAP;
`else
                w_state_nxt    = S_FETCH;
`endif
              end
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
`ifdef NOTE_GAP_EN
      S_GAP: begin
        w_tone_en_nxt = 1'b0;
        if (tick) begin
          if (r_gap_cnt == GAP_LAST) w_state_nxt = S_FETCH;
          else w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
`endif
      S_DONE: begin
        w_tone_en_nxt  = 1'b0;
        w_rom_addr_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_rom_addr_nxt = '0;
      w_tone_en_nxt  = 1'b0;
    end
  end

  // State and registered outputs; busy/done derive from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_div_limit <= '0;
      r_tone_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tick_cnt  <= '0;
      r_unit_cnt  <= '0;
`ifdef NOTE_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_div_limit <= w_div_limit_nxt;
      r_tone_en   <= w_tone_en_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_unit_cnt  <= w_unit_cnt_nxt;
`ifdef NOTE_GAP_EN
      r_gap_cnt   <= w_gap_cnt_nxt;
`endif
    end
  end

  assign rom_addr  = r_rom_addr;
  assign div_limit = r_div_limit;
  assign tone_en   = r_tone_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: song table with a done-driven scoreboard plus
// hand-written sequences for gap timing, start/stop, reset and address wrap.
module tb_note_scheduler;

  localparam int unsigned UT = 4;
  localparam int unsigned GT = 2;
  localparam int unsigned TP = 5;
`ifdef NOTE_GAP_EN
  localparam int GAP_EXP = GT;
`else
  localparam int GAP_EXP = 0;
`endif

  typedef struct {
    logic [3:0][15:0] words;
    int               tone_ticks;
    int               rises;
    logic [11:0]      last_div;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, tick, start2;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic [11:0] div_limit;
  logic        tone_en, busy, done;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2;
  logic [11:0] div_limit2;
  logic        tone_en2, busy2, done2;

  logic [15:0] rom_mem [0:63];
  vec_t        vecs [6];
  vec_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          done_total = 0;
  int          acc_tone, acc_rises;
  logic        prev_busy, prev_tone, prev_done;

  always #5 clk = ~clk;

  note_scheduler #(.ADDR_W(6), .UNIT_TICKS(UT), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tick(tick),
    .rom_addr(rom_addr), .rom_data(rom_data), .div_limit(div_limit),
    .tone_en(tone_en), .busy(busy), .done(done)
  );

  note_scheduler #(.ADDR_W(2), .UNIT_TICKS(UT), .GAP_TICKS(GT)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .tick(tick),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .div_limit(div_limit2),
    .tone_en(tone_en2), .busy(busy2), .done(done2)
  );

  // Synchronous song ROMs
  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  always @(posedge clk) rom_data2 <= 16'h1010;

  // Tick strobe: one cycle high every TP cycles
  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tcnt == TP - 1);
      tcnt = (tcnt == TP - 1) ? 0 : tcnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3,
                              input int tt, input int r, input logic [11:0] d);
    vec_t v;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.tone_ticks = tt; v.rises = r; v.last_div = d;
    return v;
  endfunction

  // Accumulates per-song observations and scores them on each done pulse
  task automatic monitor();
    vec_t e;
    prev_busy = 1'b0; prev_tone = 1'b0; prev_done = 1'b0;
    acc_tone = 0; acc_rises = 0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin acc_tone = 0; acc_rises = 0; end
      if (tick && tone_en) acc_tone++;
      if (tone_en && !prev_tone) acc_rises++;
      if (prev_done) check("busy_after_done", int'(busy), 0);
      if (done) begin
        done_total++;
        check("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("tone_ticks", acc_tone, e.tone_ticks);
          check("tone_rises", acc_rises, e.rises);
          check("div_limit_end", int'(div_limit), int'(e.last_div));
        end
      end
      prev_busy = busy; prev_tone = tone_en; prev_done = done;
    end
  endtask

  task automatic load_rom(input vec_t v);
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom_mem[i] = v.words[i];
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check(name, int'(n < 3000), 1);
  endtask

  task automatic wait_tone(input string name);
    int n;
    n = 0;
    while (!tone_en && n < 500) begin @(negedge clk); n++; end
    check(name, int'(n < 500), 1);
  endtask

  initial begin
    int d0, lt, cyc, n, tt, r;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_div_limit", int'(div_limit), 0);
    check("rst_tone_en", int'(tone_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy2", int'(busy2), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    fork monitor(); join_none

    vecs[0] = mk(16'h1100, 16'h2200, 16'h0000, 16'h0000, 3 * UT, 2, 12'h200);
    vecs[1] = mk(16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 12'h000);
    vecs[2] = mk(16'h3ABC, 16'h0000, 16'h0000, 16'h0000, 3 * UT, 1, 12'hABC);
    vecs[3] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 12'hABC);
    vecs[4] = mk(16'h1123, 16'h1000, 16'h2456, 16'h0000, 3 * UT, 2, 12'h456);
    vecs[5] = mk(16'hF001, 16'h0000, 16'h0000, 16'h0000, 15 * UT, 1, 12'h001);

    for (int i = 0; i < 6; i++) begin
      load_rom(vecs[i]);
      d0 = done_total;
      sb.push_back(vecs[i]);
      pulse_start();
      check("busy_after_start", int'(busy), 1);
      wait_idle("vec_timeout");
      @(negedge clk);
      check("vec_done_count", done_total - d0, 1);
    end

    // Silence between consecutive notes, measured from the last tick of note 1
    load_rom(vecs[0]);
    sb.push_back(vecs[0]);
    pulse_start();
    wait_tone("gap_tone1");
    cyc = 0; lt = -1000;
    while (tone_en && cyc < 1000) begin
      if (tick) lt = cyc;
      @(negedge clk); cyc++;
    end
    while (!tone_en && cyc < 1000) begin @(negedge clk); cyc++; end
    check("gap_cycles", cyc - lt, GAP_EXP * TP + 3);
    wait_idle("gap_timeout");

    // start during PLAY is ignored; scoreboard confirms unchanged duration
    load_rom(mk(16'h2300, 16'h0000, 16'h0000, 16'h0000, 2 * UT, 1, 12'h300));
    sb.push_back(mk(16'h2300, 16'h0000, 16'h0000, 16'h0000, 2 * UT, 1, 12'h300));
    pulse_start();
    wait_tone("restart_tone");
    repeat (7) @(negedge clk);
    pulse_start();
    @(negedge clk);
    check("restart_rom_addr", int'(rom_addr), 0);
    check("restart_busy", int'(busy), 1);
    wait_idle("restart_timeout");

    // stop mid-PLAY aborts with no done pulse; div_limit holds
    d0 = done_total;
    pulse_start();
    wait_tone("stop_tone");
    repeat (8) @(negedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check("stop_busy", int'(busy), 0);
    check("stop_tone_en", int'(tone_en), 0);
    check("stop_rom_addr", int'(rom_addr), 0);
    check("stop_div_hold", int'(div_limit), 12'h300);
    repeat (100) @(negedge clk);
    check("stop_no_done", done_total - d0, 0);

    // start together with stop in IDLE stays IDLE
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
    @(negedge clk);
    check("startstop_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("startstop_busy_later", int'(busy), 0);

    // ADDR_W=2: four notes, then DONE at address 3 without wrapping to 0
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0; tt = 0; r = 0; prev_tone = 1'b0;
    begin
      logic pt;
      pt = 1'b0;
      while (busy2 && n < 3000) begin
        @(negedge clk); n++;
        if (tick && tone_en2) tt++;
        if (tone_en2 && !pt) r++;
        if (done2) check("wrap_done_addr", int'(rom_addr2), 3);
        pt = tone_en2;
      end
    end
    check("wrap_timeout", int'(n < 3000), 1);
    check("wrap_notes", r, 4);
    check("wrap_tone_ticks", tt, 4 * UT);
    check("wrap_div", int'(div_limit2), 12'h010);

    // Reset during PLAY takes effect at once with no done pulse
    d0 = done_total;
    pulse_start();
    wait_tone("rstplay_tone");
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstplay_busy", int'(busy), 0);
    check("rstplay_tone_en", int'(tone_en), 0);
    check("rstplay_div", int'(div_limit), 0);
    check("rstplay_rom_addr", int'(rom_addr), 0);
    repeat (100) @(negedge clk);
    check("rstplay_no_done", done_total - d0, 0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
